// File: rtl/param_sched.sv
// param_sched: shadow/active parameter bank with sample-aligned commit,
// plus an on/off sequencer that ramps the output gain up and down.
module param_sched #(
    parameter int unsigned RAMP_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_addr,
    input  logic [23:0] cfg_data,
    input  logic        commit,
    input  logic        on_req,
    output logic [23:0] frec_mod_o,
    output logic [23:0] frec_por_o,
    output logic [15:0] im_am_o,
    output logic [15:0] im_fm_o,
    output logic [15:0] gain_o,
    output logic        dp_rst,
    output logic        val_o,
    output logic        busy,
    output logic        pending
);

    localparam int unsigned FREC_W     = 24;
    localparam int unsigned IM_W       = 16;
    localparam int unsigned GAIN_W     = 16;
    localparam int unsigned GAIN_SHIFT = GAIN_W - RAMP_LOG2;

    localparam logic [RAMP_LOG2-1:0] CNT_ZERO = '0;
    localparam logic [RAMP_LOG2-1:0] CNT_MAX  = '1;
    localparam logic [RAMP_LOG2-1:0] CNT_ONE  = RAMP_LOG2'(1);

    localparam logic [GAIN_W-1:0] GAIN_ZERO  = '0;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = '1;

    // One complete parameter set; shadow and active banks share the layout.
    typedef struct packed {
        logic [FREC_W-1:0] frec_mod;
        logic [FREC_W-1:0] frec_por;
        logic [IM_W-1:0]   im_am;
        logic [IM_W-1:0]   im_fm;
    } param_set_t;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_e;

    param_set_t           shadow_q,  shadow_d;
    param_set_t           active_q,  active_d;
    logic                 pending_q, pending_d;
    logic                 val_q,     val_d;
    state_e               state_q,   state_d;
    logic [RAMP_LOG2-1:0] cnt_q,     cnt_d;
    logic [GAIN_W-1:0]    gain_q,    gain_d;
    logic                 dp_rst_q,  dp_rst_d;
    logic                 busy_q,    busy_d;
    logic                 load_c;

    // Shadow register write decode; addresses 4..7 fall through untouched.
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_wr) begin
            case (cfg_addr)
                3'd0:    shadow_d.frec_mod = cfg_data;
                3'd1:    shadow_d.frec_por = cfg_data;
                3'd2:    shadow_d.im_am    = cfg_data[IM_W-1:0];
                3'd3:    shadow_d.im_fm    = cfg_data[IM_W-1:0];
                default: shadow_d = shadow_q;
            endcase
        end
    end

    // Commit handshake: a load on a sample strobe takes the pre-edge shadow,
    // so a same-cycle write lands in shadow only and waits for the next commit.
    always_comb begin
        load_c    = ce & (pending_q | commit);
        active_d  = active_q;
        pending_d = pending_q;
        if (load_c) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end
    end

    // Output-valid strobe trails the sample strobe by one cycle, lining up
    // with the first cycle the freshly loaded parameters are visible.
    always_comb begin
        val_d = ce;
    end

    // On/off sequencer next state; on_req reversals win over ce.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (on_req) begin
                    state_d = ST_RAMP_UP;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_RAMP_UP: begin
                if (!on_req) begin
                    state_d = ST_RAMP_DOWN;
                end else if (ce) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_RUN: begin
                if (!on_req) begin
                    state_d = ST_RAMP_DOWN;
                    cnt_d   = CNT_MAX;
                end
            end
            ST_RAMP_DOWN: begin
                if (on_req) begin
                    state_d = ST_RAMP_UP;
                end else if (ce) begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = ST_OFF;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Status decode from the next state so the registered outputs track
    // the state register with no added latency.
    always_comb begin
        gain_d   = GAIN_ZERO;
        dp_rst_d = 1'b0;
        busy_d   = 1'b0;
        case (state_d)
            ST_OFF: begin
                dp_rst_d = 1'b1;
            end
            ST_RAMP_UP, ST_RAMP_DOWN: begin
                gain_d = GAIN_W'({cnt_d, {GAIN_SHIFT{1'b0}}});
                busy_d = 1'b1;
            end
            ST_RUN: begin
                gain_d = GAIN_UNITY;
            end
            default: begin
                dp_rst_d = 1'b1;
            end
        endcase
    end

    // State and data registers with synchronous reset; reset also drops any
    // pending commit and wipes the shadow bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            val_q     <= 1'b0;
            state_q   <= ST_OFF;
            cnt_q     <= CNT_ZERO;
            gain_q    <= GAIN_ZERO;
            dp_rst_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            val_q     <= val_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gain_q    <= gain_d;
            dp_rst_q  <= dp_rst_d;
            busy_q    <= busy_d;
        end
    end

    assign frec_mod_o = active_q.frec_mod;
    assign frec_por_o = active_q.frec_por;
    assign im_am_o    = active_q.im_am;
    assign im_fm_o    = active_q.im_fm;
    assign gain_o     = gain_q;
    assign dp_rst     = dp_rst_q;
    assign val_o      = val_q;
    assign busy       = busy_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_param_sched.sv
// Directed testbench for param_sched (RAMP_LOG2 = 4).
module tb_param_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic        commit;
    logic        on_req;
    logic [23:0] frec_mod_o;
    logic [23:0] frec_por_o;
    logic [15:0] im_am_o;
    logic [15:0] im_fm_o;
    logic [15:0] gain_o;
    logic        dp_rst;
    logic        val_o;
    logic        busy;
    logic        pending;

    int tests_run    = 0;
    int tests_failed = 0;

    param_sched #(.RAMP_LOG2(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .commit     (commit),
        .on_req     (on_req),
        .frec_mod_o (frec_mod_o),
        .frec_por_o (frec_por_o),
        .im_am_o    (im_am_o),
        .im_fm_o    (im_fm_o),
        .gain_o     (gain_o),
        .dp_rst     (dp_rst),
        .val_o      (val_o),
        .busy       (busy),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [23:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_wr   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({frec_mod_o, frec_por_o, im_am_o, im_fm_o, gain_o} !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 0", {frec_mod_o, frec_por_o, im_am_o, im_fm_o, gain_o});
        end
        tests_run++;
        if ({dp_rst, val_o, busy, pending} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 1000", {dp_rst, val_o, busy, pending});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_commit_load();
        cfg_write(3'd0, 24'h123456);
        cfg_write(3'd1, 24'h654321);
        cfg_write(3'd2, 24'h005555);
        cfg_write(3'd3, 24'h007777);
        cfg_write(3'd4, 24'hFFFFFF);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tests_run++;
        if ({pending, frec_mod_o} !== {1'b1, 24'h0}) begin
            tests_failed++;
            $display("FAIL commit_pending: got %h expected %h", {pending, frec_mod_o}, {1'b1, 24'h0});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({val_o, frec_mod_o} !== 25'h0) begin
                tests_failed++;
                $display("FAIL commit_wait%0d: got %h expected 0", i, {val_o, frec_mod_o});
            end
        end
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tests_run++;
        if ({frec_mod_o, frec_por_o, im_am_o, im_fm_o} !== {24'h123456, 24'h654321, 16'h5555, 16'h7777}) begin
            tests_failed++;
            $display("FAIL commit_load: got %h expected %h", {frec_mod_o, frec_por_o, im_am_o, im_fm_o},
                     {24'h123456, 24'h654321, 16'h5555, 16'h7777});
        end
        tests_run++;
        if ({val_o, pending} !== 2'b10) begin
            tests_failed++;
            $display("FAIL commit_val: got %b expected 10", {val_o, pending});
        end
        tick();
        tests_run++;
        if (val_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL val_width: got %b expected 0", val_o);
        end
    endtask

    task automatic test_double_commit();
        commit = 1'b1;
        tick();
        tick();
        commit = 1'b0;
        tests_run++;
        if (pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL dbl_pending: got %b expected 1", pending);
        end
        cfg_write(3'd3, 24'h001234);
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tests_run++;
        if ({pending, im_fm_o} !== {1'b0, 16'h1234}) begin
            tests_failed++;
            $display("FAIL dbl_load: got %h expected %h", {pending, im_fm_o}, {1'b0, 16'h1234});
        end
        cfg_write(3'd3, 24'h004321);
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tests_run++;
        if (im_fm_o !== 16'h1234) begin
            tests_failed++;
            $display("FAIL dbl_noreload: got %h expected 1234", im_fm_o);
        end
    endtask

    task automatic test_same_cycle();
        cfg_write(3'd2, 24'h000001);
        cfg_wr   = 1'b1;
        cfg_addr = 3'd2;
        cfg_data = 24'h00BEEF;
        commit   = 1'b1;
        ce       = 1'b1;
        tick();
        cfg_wr = 1'b0;
        tests_run++;
        if ({im_am_o, pending, val_o} !== {16'h0001, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL same_cycle: got %h expected %h", {im_am_o, pending, val_o}, {16'h0001, 1'b0, 1'b1});
        end
        tick();
        commit = 1'b0;
        ce     = 1'b0;
        tests_run++;
        if (im_am_o !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL same_cycle_shadow: got %h expected beef", im_am_o);
        end
    endtask

    task automatic test_ramp_up();
        logic [15:0] exp_gain;
        on_req = 1'b1;
        tick();
        tests_run++;
        if ({dp_rst, busy, gain_o} !== {1'b0, 1'b1, 16'h0000}) begin
            tests_failed++;
            $display("FAIL up_start: got %h expected %h", {dp_rst, busy, gain_o}, {1'b0, 1'b1, 16'h0000});
        end
        for (int i = 1; i <= 16; i++) begin
            ce = 1'b1;
            tick();
            ce = 1'b0;
            exp_gain = (i < 16) ? 16'(i * 4096) : 16'hFFFF;
            tests_run++;
            if ({gain_o, busy, dp_rst} !== {exp_gain, (i < 16), 1'b0}) begin
                tests_failed++;
                $display("FAIL up_step%0d: got %h expected %h", i, {gain_o, busy, dp_rst}, {exp_gain, (i < 16), 1'b0});
            end
            if (i == 8) begin
                tick();
                tests_run++;
                if (gain_o !== 16'h8000) begin
                    tests_failed++;
                    $display("FAIL up_hold: got %h expected 8000", gain_o);
                end
            end
        end
        cfg_write(3'd0, 24'h0A0B0C);
        commit = 1'b1;
        ce     = 1'b1;
        tick();
        commit = 1'b0;
        ce     = 1'b0;
        tests_run++;
        if ({frec_mod_o, gain_o} !== {24'h0A0B0C, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL run_commit: got %h expected %h", {frec_mod_o, gain_o}, {24'h0A0B0C, 16'hFFFF});
        end
    endtask

    task automatic test_ramp_down();
        logic [15:0] exp_gain;
        on_req = 1'b0;
        tick();
        tests_run++;
        if ({gain_o, busy, dp_rst} !== {16'hF000, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL down_start: got %h expected %h", {gain_o, busy, dp_rst}, {16'hF000, 1'b1, 1'b0});
        end
        for (int i = 1; i <= 16; i++) begin
            ce = 1'b1;
            tick();
            ce = 1'b0;
            exp_gain = (i < 16) ? 16'((15 - i) * 4096) : 16'h0000;
            tests_run++;
            if ({gain_o, busy, dp_rst} !== {exp_gain, (i < 16), (i == 16)}) begin
                tests_failed++;
                $display("FAIL down_step%0d: got %h expected %h", i, {gain_o, busy, dp_rst},
                         {exp_gain, (i < 16), (i == 16)});
            end
        end
    endtask

    task automatic test_reversal();
        on_req = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            ce = 1'b1;
            tick();
            ce = 1'b0;
        end
        tests_run++;
        if (gain_o !== 16'h5000) begin
            tests_failed++;
            $display("FAIL rev_cnt5: got %h expected 5000", gain_o);
        end
        on_req = 1'b0;
        ce     = 1'b1;
        tick();
        ce     = 1'b0;
        tests_run++;
        if ({gain_o, busy} !== {16'h5000, 1'b1}) begin
            tests_failed++;
            $display("FAIL rev_down_hold: got %h expected %h", {gain_o, busy}, {16'h5000, 1'b1});
        end
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tests_run++;
        if (gain_o !== 16'h4000) begin
            tests_failed++;
            $display("FAIL rev_down_step: got %h expected 4000", gain_o);
        end
        on_req = 1'b1;
        ce     = 1'b1;
        tick();
        tests_run++;
        if (gain_o !== 16'h4000) begin
            tests_failed++;
            $display("FAIL rev_up_hold: got %h expected 4000", gain_o);
        end
        tick();
        ce = 1'b0;
        tests_run++;
        if (gain_o !== 16'h5000) begin
            tests_failed++;
            $display("FAIL rev_up_step: got %h expected 5000", gain_o);
        end
        on_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        cfg_write(3'd0, 24'hABCDEF);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tests_run++;
        if ({pending, busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rst_pre: got %b expected 11", {pending, busy});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({frec_mod_o, frec_por_o, im_am_o, im_fm_o, gain_o, val_o, busy, pending, dp_rst} !== {100'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_mid: got %h expected %h",
                     {frec_mod_o, frec_por_o, im_am_o, im_fm_o, gain_o, val_o, busy, pending, dp_rst}, {100'h0, 1'b1});
        end
        commit = 1'b1;
        ce     = 1'b1;
        tick();
        commit = 1'b0;
        ce     = 1'b0;
        tests_run++;
        if ({frec_mod_o, im_am_o, val_o, dp_rst} !== {24'h0, 16'h0, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_shadow: got %h expected %h", {frec_mod_o, im_am_o, val_o, dp_rst},
                     {24'h0, 16'h0, 1'b1, 1'b1});
        end
    endtask

    initial begin
        rst      = 1'b1;
        ce       = 1'b0;
        cfg_wr   = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 24'h0;
        commit   = 1'b0;
        on_req   = 1'b0;
        test_reset();
        test_commit_load();
        test_double_commit();
        test_same_cycle();
        test_ramp_up();
        test_ramp_down();
        test_reversal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/param_sched.md
PARAM_SCHED -- requirements
Module: param_sched

Interface
REQ-001 SHALL have parameter RAMP_LOG2, default 4, log2 of the mute/unmute ramp length in samples (legal range 1..8).
REQ-002 SHALL have port clk  in  1  system clock (98 MHz modulator domain); the block uses one clock only.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port ce  in  1  sample strobe, one clk cycle wide (48 kHz rate).
REQ-005 SHALL have port cfg_wr  in  1  shadow-register write strobe.
REQ-006 SHALL have port cfg_addr  in  3  shadow-register select.
REQ-007 SHALL have port cfg_data  in  24  write data.
REQ-008 SHALL have port commit  in  1  request to transfer shadow to active at the next sample.
REQ-009 SHALL have port on_req  in  1  level; 1 = modulator on, 0 = off.
REQ-010 SHALL have ports frec_mod_o and frec_por_o  out  24 each, and im_am_o and im_fm_o  out  16 each, all active parameters.
REQ-011 SHALL have port gain_o  out  16  unsigned output gain (0xFFFF = unity).
REQ-012 SHALL have port dp_rst  out  1  datapath hold-in-reset.
REQ-013 SHALL have ports val_o  out  1 (ce delayed one cycle), busy  out  1 (ramp in progress) and pending  out  1 (commit outstanding).

Function
REQ-014 SHALL decode cfg_wr with cfg_addr 0/1/2/3 as writes of the shadow frec_mod, frec_por, im_am and im_fm registers; 16-bit registers take cfg_data[15:0]; addresses 4-7 SHALL be ignored.
REQ-015 SHALL set pending on a commit pulse; an additional commit while pending is already set SHALL have no further effect.
REQ-016 SHALL, on a cycle with ce=1 and (pending=1 or commit=1), load all four active registers from the shadow values held before that edge and clear pending.
REQ-017 SHALL, when cfg_wr and a commit-load occur in the same cycle, load the active register with the old shadow value, update the shadow, and leave pending at 0.
REQ-018 SHALL assert val_o exactly one cycle after each ce, so that val_o coincides with the first cycle in which newly loaded parameters are visible.
REQ-019 SHALL implement a state machine with states OFF, RAMP_UP, RUN and RAMP_DOWN, plus a RAMP_LOG2-bit counter cnt.
REQ-020 SHALL, in OFF, move to RAMP_UP with cnt=0 when on_req=1.
REQ-021 SHALL, in RAMP_UP, move to RAMP_DOWN with cnt unchanged if on_req=0; otherwise, on ce, move to RUN if cnt=2^RAMP_LOG2-1, else increment cnt.
REQ-022 SHALL, in RUN, move to RAMP_DOWN with cnt=2^RAMP_LOG2-1 when on_req=0.
REQ-023 SHALL, in RAMP_DOWN, move to RAMP_UP with cnt unchanged if on_req=1; otherwise, on ce, move to OFF if cnt=0, else decrement cnt.
REQ-024 SHALL give on_req priority over ce in the same cycle (direction reversal takes effect and the counter does not move in that cycle).
REQ-025 SHALL drive gain_o as 0 in OFF, 0xFFFF in RUN, and cnt shifted left by (16-RAMP_LOG2) in both ramp states, decoded directly from registered state with no extra latency.
REQ-026 SHALL drive dp_rst=1 only in OFF and busy=1 only in RAMP_UP or RAMP_DOWN.
REQ-027 SHALL accept parameter writes and commits in every state; commits are not gated by the on/off state.

Reset
REQ-028 SHALL, while rst=1 at a clk edge, clear all shadow and active registers and also clear pending, cnt, gain_o and val_o, set the state to OFF, and set dp_rst=1.
REQ-029 SHALL, on reset mid-ramp or with a commit pending, abandon the ramp, discard the pending commit, and keep the shadow contents cleared.

Verification
REQ-030 SHALL cover this scenario: write addr0=0x123456, commit, ce 5 cycles later -> frec_mod_o stays 0 until the ce edge, is 0x123456 afterwards, pending falls, and val_o pulses together with the new value.
REQ-031 SHALL cover this scenario: commit and ce in the same cycle as cfg_wr addr2=0xBEEF (shadow previously 0x0001) -> im_am_o=0x0001, shadow=0xBEEF, pending=0.
REQ-032 SHALL cover this scenario: RAMP_LOG2=4, raise on_req, apply 16 ce pulses -> dp_rst falls immediately, gain_o steps 0x0000, 0x1000 ... 0xF000, then goes to 0xFFFF in RUN and busy falls.
REQ-033 SHALL cover this scenario: in RUN, drop on_req, apply 16 ce pulses -> gain_o goes 0xF000 down to 0x0000, the state reaches OFF, and dp_rst=1.
REQ-034 SHALL cover this scenario: drop on_req at cnt=5 of RAMP_UP, in the same cycle as ce -> RAMP_DOWN with gain 0x5000 held, and the next ce gives 0x4000.
REQ-035 SHALL cover this scenario: assert rst during RAMP_DOWN with pending=1 -> next cycle all outputs are 0, except dp_rst=1.
